// File: rtl/mcyc_pkg.sv
// Shared state encodings, RV32I major opcodes and opcode classifier for the
// multi-cycle sequencer.
package mcyc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_BRANCH,
        CL_LOAD,
        CL_STORE,
        CL_ILLEGAL
    } op_class_t;

    function automatic op_class_t decode_op(input logic [6:0] op);
        op_class_t cl;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: cl = CL_ALU;
            OP_BRANCH: cl = CL_BRANCH;
            OP_LOAD:   cl = CL_LOAD;
            OP_STORE:  cl = CL_STORE;
            default:   cl = CL_ILLEGAL;
        endcase
        return cl;
    endfunction

endpackage

// File: rtl/mcyc_instret.sv
// Retired-instruction counter; increments once per inc pulse and wraps silently.
module mcyc_instret #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/mcyc_seq.sv
// Multi-cycle instruction sequencer with shared memory port and retire counter.
// Optional MCYC_ILLEGAL_TRAP_EN: unknown opcodes trap instead of retiring as NOP.
//
// state  | meaning
// FETCH  | request instruction at PC; load IR on run & mem_ready
// DECODE | one-cycle decode slot
// EXEC   | ALU cycle; branches retire here
// MEM    | data access at ALU result, held until mem_ready
// WB     | register write and retire
// TRAP   | illegal opcode seen; frozen until reset
module mcyc_seq
    import mcyc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_data,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    state_t    state_q, state_d;
    op_class_t op_cl;
    logic      set_illegal;

    assign op_cl = decode_op(opcode);
    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_is_data = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = run;
                if (run && mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (op_cl)
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_ALU:            state_d = ST_WB;
                    CL_BRANCH: begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: begin
`ifdef MCYC_ILLEGAL_TRAP_EN
                        set_illegal = 1'b1;
                        state_d     = ST_TRAP;
`else
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                mem_is_data = 1'b1;
                mem_we      = (op_cl == CL_STORE);
                if (mem_ready) begin
                    if (op_cl == CL_STORE) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
            end
`ifdef MCYC_ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
        // FETCH strobes depend on live inputs, so mask them while reset is held.
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_is_data = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            reg_we      = 1'b0;
            set_illegal = 1'b0;
        end
    end

`ifdef MCYC_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (set_illegal)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    mcyc_instret #(
        .CNT_W(CNT_W)
    ) u_instret (
        .clk  (clk),
        .rst  (rst),
        .inc  (pc_we),
        .count(instret)
    );

endmodule
